// File: rtl/only_output_generator_if.sv
// only_output_generator_if: run/config/stream bundle for the sequence source unit
// Ports (slave view): run_i start pulse; cfg_start_i/cfg_incr_i/cfg_iter_i/cfg_delay_i
// sequence config; out0_o stream word; out_valid_o word qualifier; running_o busy; done_o end pulse
interface only_output_generator_if #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 8
);
    logic               run_i;
    logic [DATA_W-1:0]  cfg_start_i;
    logic [DATA_W-1:0]  cfg_incr_i;
    logic [DATA_W-1:0]  cfg_iter_i;
    logic [DELAY_W-1:0] cfg_delay_i;
    logic [DATA_W-1:0]  out0_o;
    logic               out_valid_o;
    logic               running_o;
    logic               done_o;
    modport master (
        output run_i, cfg_start_i, cfg_incr_i, cfg_iter_i, cfg_delay_i,
        input  out0_o, out_valid_o, running_o, done_o
    );
    modport slave (
        input  run_i, cfg_start_i, cfg_incr_i, cfg_iter_i, cfg_delay_i,
        output out0_o, out_valid_o, running_o, done_o
    );
endinterface

// File: rtl/only_output_generator.sv
// only_output_generator: emits start+i*incr for i=0..iter-1 after an optional start-up delay
// Ports: clk clock; rst_n async active-low reset; bus (slave) carries run/config in and
// out0/out_valid/running/done out, all outputs registered
module only_output_generator #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    only_output_generator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DELAY, GEN} state_t;
    state_t             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0]  start_q, start_d;
    logic [DATA_W-1:0]  incr_q, incr_d;
    logic [DATA_W-1:0]  out0_q, out0_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            start_q <= '0;
            incr_q  <= '0;
            out0_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            start_q <= start_d;
            incr_q  <= incr_d;
            out0_q  <= out0_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        start_d = start_q;
        incr_d  = incr_q;
        out0_d  = out0_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            DELAY: begin
                cnt_d = cnt_q - DELAY_W'(1);
                // a zero-length sequence ends as soon as the delay expires
                if (cnt_q <= DELAY_W'(1)) begin
                    state_d = (rem_q == '0) ? IDLE : GEN;
                    done_d  = (rem_q == '0);
                    out0_d  = (rem_q == '0) ? out0_q : start_q;
                    valid_d = (rem_q != '0);
                end
            end
            GEN: begin
                rem_d   = (rem_q == '0) ? '0 : rem_q - DATA_W'(1);
                out0_d  = (rem_q > DATA_W'(1)) ? out0_q + incr_q : out0_q;
                valid_d = (rem_q > DATA_W'(1));
                done_d  = (rem_q <= DATA_W'(1));
                state_d = (rem_q > DATA_W'(1)) ? GEN : IDLE;
            end
            default: ;
        endcase
        // restart overrides whatever the current sequence was doing; a done raised
        // on this same edge by a naturally finishing sequence is kept
        if (bus.run_i) begin
            start_d = bus.cfg_start_i;
            incr_d  = bus.cfg_incr_i;
            rem_d   = bus.cfg_iter_i;
            cnt_d   = bus.cfg_delay_i;
            state_d = (bus.cfg_delay_i != '0) ? DELAY : GEN;
            out0_d  = (bus.cfg_delay_i != '0) ? out0_q : bus.cfg_start_i;
            valid_d = (bus.cfg_delay_i == '0) && (bus.cfg_iter_i != '0);
        end
    end
    assign bus.out0_o      = out0_q;
    assign bus.out_valid_o = valid_q;
    assign bus.running_o   = (state_q != IDLE);
    assign bus.done_o      = done_q;
endmodule

// File: tb/tb_only_output_generator.sv
// tb_only_output_generator: directed checks of the sequence source unit
module tb_only_output_generator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   d0;
    only_output_generator_if #(.DATA_W(32), .DELAY_W(8)) bus ();
    only_output_generator #(.DATA_W(32), .DELAY_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.done_o) done_cnt <= done_cnt + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [31:0] s, input logic [31:0] inc, input logic [31:0] it, input logic [7:0] dl);
        bus.cfg_start_i = s;
        bus.cfg_incr_i  = inc;
        bus.cfg_iter_i  = it;
        bus.cfg_delay_i = dl;
        bus.run_i       = 1'b1;
        step();
        bus.run_i       = 1'b0;
        bus.cfg_start_i = 32'hDEAD_BEEF;
        bus.cfg_incr_i  = 32'h1234_5678;
        bus.cfg_iter_i  = 32'd77;
        bus.cfg_delay_i = 8'd9;
    endtask
    initial begin
        bus.run_i = 1'b0;
        bus.cfg_start_i = '0;
        bus.cfg_incr_i = '0;
        bus.cfg_iter_i = '0;
        bus.cfg_delay_i = '0;
        #12;
        chk("rst_out0", bus.out0_o, 32'd0);
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_running", 32'(bus.running_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        rst_n = 1'b1;
        step();
        start(32'd5, 32'd3, 32'd4, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 32'(bus.out_valid_o), 32'd1);
            chk("t1_out0", bus.out0_o, 32'(5 + 3 * i));
            chk("t1_done_early", 32'(bus.done_o), 32'd0);
            step();
        end
        chk("t1_done", 32'(bus.done_o), 32'd1);
        chk("t1_valid_end", 32'(bus.out_valid_o), 32'd0);
        chk("t1_running_end", 32'(bus.running_o), 32'd0);
        step();
        chk("t1_done_pulse", 32'(bus.done_o), 32'd0);
        chk("t1_hold", bus.out0_o, 32'd14);
        start(32'd0, 32'd1, 32'd2, 8'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_delay_valid", 32'(bus.out_valid_o), 32'd0);
            chk("t2_delay_running", 32'(bus.running_o), 32'd1);
            step();
        end
        chk("t2_w0_valid", 32'(bus.out_valid_o), 32'd1);
        chk("t2_w0", bus.out0_o, 32'd0);
        step();
        chk("t2_w1_valid", 32'(bus.out_valid_o), 32'd1);
        chk("t2_w1", bus.out0_o, 32'd1);
        chk("t2_running", 32'(bus.running_o), 32'd1);
        step();
        chk("t2_done", 32'(bus.done_o), 32'd1);
        chk("t2_running_end", 32'(bus.running_o), 32'd0);
        chk("t2_valid_end", 32'(bus.out_valid_o), 32'd0);
        step();
        start(32'hFFFF_FFFE, 32'd1, 32'd3, 8'd0);
        chk("t3_w0", bus.out0_o, 32'hFFFF_FFFE);
        step();
        chk("t3_w1", bus.out0_o, 32'hFFFF_FFFF);
        step();
        chk("t3_w2", bus.out0_o, 32'h0000_0000);
        chk("t3_w2_valid", 32'(bus.out_valid_o), 32'd1);
        step();
        chk("t3_done", 32'(bus.done_o), 32'd1);
        step();
        d0 = done_cnt;
        start(32'd9, 32'd9, 32'd0, 8'd2);
        chk("t4_c1_running", 32'(bus.running_o), 32'd1);
        chk("t4_c1_valid", 32'(bus.out_valid_o), 32'd0);
        step();
        chk("t4_c2_running", 32'(bus.running_o), 32'd1);
        chk("t4_c2_done", 32'(bus.done_o), 32'd0);
        step();
        chk("t4_done", 32'(bus.done_o), 32'd1);
        chk("t4_running_end", 32'(bus.running_o), 32'd0);
        chk("t4_valid", 32'(bus.out_valid_o), 32'd0);
        step();
        chk("t4_done_pulse", 32'(bus.done_o), 32'd0);
        step();
        chk("t4_done_count", 32'(done_cnt - d0), 32'd1);
        start(32'd1, 32'd1, 32'd0, 8'd0);
        chk("t4b_running", 32'(bus.running_o), 32'd1);
        chk("t4b_valid", 32'(bus.out_valid_o), 32'd0);
        step();
        chk("t4b_done", 32'(bus.done_o), 32'd1);
        step();
        d0 = done_cnt;
        start(32'd1000, 32'd10, 32'd10, 8'd0);
        chk("t5_w0", bus.out0_o, 32'd1000);
        step();
        chk("t5_w1", bus.out0_o, 32'd1010);
        step();
        chk("t5_w2", bus.out0_o, 32'd1020);
        start(32'd100, 32'd0, 32'd2, 8'd0);
        chk("t5_n0", bus.out0_o, 32'd100);
        chk("t5_n0_valid", 32'(bus.out_valid_o), 32'd1);
        chk("t5_no_abort_done", 32'(bus.done_o), 32'd0);
        step();
        chk("t5_n1", bus.out0_o, 32'd100);
        step();
        chk("t5_done", 32'(bus.done_o), 32'd1);
        chk("t5_valid_end", 32'(bus.out_valid_o), 32'd0);
        step();
        step();
        chk("t5_done_count", 32'(done_cnt - d0), 32'd1);
        start(32'd40, 32'd2, 32'd1, 8'd0);
        chk("t7_w0", bus.out0_o, 32'd40);
        step();
        chk("t7_done", 32'(bus.done_o), 32'd1);
        start(32'd70, 32'd5, 32'd2, 8'd0);
        chk("t7_restart_w0", bus.out0_o, 32'd70);
        chk("t7_restart_valid", 32'(bus.out_valid_o), 32'd1);
        chk("t7_restart_done", 32'(bus.done_o), 32'd0);
        step();
        chk("t7_restart_w1", bus.out0_o, 32'd75);
        step();
        step();
        d0 = done_cnt;
        start(32'd500, 32'd1, 32'd10, 8'd0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out0", bus.out0_o, 32'd0);
        chk("t6_valid", 32'(bus.out_valid_o), 32'd0);
        chk("t6_running", 32'(bus.running_o), 32'd0);
        chk("t6_done", 32'(bus.done_o), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t6_idle_valid", 32'(bus.out_valid_o), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
